fir_sample_fifo: RTL and testbench

Input sample buffer that sits directly upstream of the FIR filter. It decouples a fixed-rate sample producer (ADC / deserializer) from the multi-cycle FIR accumulation loop. It presents samples to the filter with a valid/ready handshake in which the filter's ready is a one-cycle consume pulse. It also reports occupancy and records overflow when the producer outruns the filter.

---
 rtl/fir_sample_fifo_if.sv | 41 ++++
 rtl/fir_sample_fifo.sv | 131 +++++++++++++
 tb/tb_fir_sample_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_fifo_if.sv
// ----------------------------------------------------------------------------
// fir_sample_fifo_if
// Sample-path handshake bundle between the sample producer, the input FIFO
// and the FIR filter.
//   iv_din       producer sample
//   i_din_valid  producer write strobe (one cycle per sample)
//   o_din_ready  FIFO can accept a sample
//   ov_dout      head sample presented to the FIR
//   o_dout_valid head sample valid
//   i_dout_ready one-cycle consume pulse from the FIR
// slave  : the FIFO side
// master : the producer/FIR side (testbench)
// ----------------------------------------------------------------------------
interface fir_sample_fifo_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] iv_din;
  logic                  i_din_valid;
  logic                  o_din_ready;
  logic [DATA_WIDTH-1:0] ov_dout;
  logic                  o_dout_valid;
  logic                  i_dout_ready;

  modport slave (
    input  iv_din,
    input  i_din_valid,
    output o_din_ready,
    output ov_dout,
    output o_dout_valid,
    input  i_dout_ready
  );

  modport master (
    output iv_din,
    output i_din_valid,
    input  o_din_ready,
    input  ov_dout,
    input  o_dout_valid,
    output i_dout_ready
  );
endinterface

// File: rtl/fir_sample_fifo.sv
// ----------------------------------------------------------------------------
// fir_sample_fifo
// First-word-fall-through sample buffer in front of the FIR filter. Samples
// are stored in an inferred simple dual-port RAM; the head sample is read
// into a registered output stage and held until the FIR consumes it.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              global enable, low freezes all state
//   i_clr_ovf         clears the sticky overflow flag and drop counter
//   s_bus             sample handshake (slave side of fir_sample_fifo_if)
//   ov_level          samples held (RAM + output register)
//   o_almost_full     ov_level >= ALMOST_FULL_THRESH
//   o_overflow        sticky: a sample was dropped
//   ov_drop_count     dropped samples, saturating
// ----------------------------------------------------------------------------
module fir_sample_fifo #(
  parameter int DATA_WIDTH         = 24,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_clr_ovf,
  fir_sample_fifo_if.slave            s_bus,
  output logic [$clog2(FIFO_DEPTH):0] ov_level,
  output logic                        o_almost_full,
  output logic                        o_overflow,
  output logic [15:0]                 ov_drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [LW-1:0]         w_level_next;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic                  r_din_ready;
  logic                  r_almost_full;
  logic                  r_overflow;
  logic [15:0]           r_drop_count;

  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_fetch;

  always_comb begin
    w_push = i_en && s_bus.i_din_valid && r_din_ready;
    w_drop = i_en && s_bus.i_din_valid && !r_din_ready;
    w_pop  = i_en && r_dout_valid && s_bus.i_dout_ready;
    // Load the output register whenever it is empty or being consumed and
    // the RAM still holds samples not yet presented (level minus the one in
    // the output register). A sample pushed this edge is not counted yet, so
    // the read never collides with the write slot.
    w_fetch = i_en && (!r_dout_valid || w_pop) && (r_level > LW'(r_dout_valid));

    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - LW'(1);
    end
  end

  // Storage: write port only, no reset of contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem[r_wr_ptr] <= s_bus.iv_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_din_ready   <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      // Flags follow the next level so they line up with ov_level.
      r_din_ready   <= (w_level_next < LW'(FIFO_DEPTH));
      r_almost_full <= (w_level_next >= LW'(ALMOST_FULL_THRESH));
      if (i_en) begin
        r_level <= w_level_next;
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        // Registered RAM read into the output stage.
        if (w_fetch) begin
          r_dout   <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_fetch) begin
          r_dout_valid <= 1'b1;
        end else if (w_pop) begin
          r_dout_valid <= 1'b0;
        end
        // A drop at the same edge as a clear wins and restarts the count at 1.
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (i_clr_ovf) begin
            r_drop_count <= 16'd1;
          end else if (r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
          end
        end else if (i_clr_ovf) begin
          r_overflow   <= 1'b0;
          r_drop_count <= '0;
        end
      end
    end
  end

  assign s_bus.o_din_ready  = r_din_ready;
  assign s_bus.ov_dout      = r_dout;
  assign s_bus.o_dout_valid = r_dout_valid;
  assign ov_level           = r_level;
  assign o_almost_full      = r_almost_full;
  assign o_overflow         = r_overflow;
  assign ov_drop_count      = r_drop_count;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// ----------------------------------------------------------------------------
// tb_fir_sample_fifo
// Bench for fir_sample_fifo: a negedge monitor keeps a level model and a
// scoreboard of accepted samples; directed sequences plus a vector table
// check flags, level, overflow and ordering.
// ----------------------------------------------------------------------------
module tb_fir_sample_fifo;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [4:0]  level;
  logic        af;
  logic        ovf;
  logic [15:0] drops;

  fir_sample_fifo_if #(.DATA_WIDTH(DW)) bus ();

  fir_sample_fifo #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .ALMOST_FULL_THRESH(AFT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_clr_ovf(clr),
    .s_bus(bus),
    .ov_level(level),
    .o_almost_full(af),
    .o_overflow(ovf),
    .ov_drop_count(drops)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_level = 0;
  int n_pop  = 0;
  bit mon_on = 1'b0;
  logic [DW-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decides what the coming edge will do from the inputs already
  // driven, compares popped samples and tracks the expected level.
  always @(negedge clk) begin
    int push_i;
    int pop_i;
    logic [DW-1:0] exp_d;
    push_i = 0;
    pop_i  = 0;
    if (rst) begin
      m_level = 0;
      sb.delete();
    end else if (mon_on) begin
      check("level_model", 32'(level), 32'(m_level));
      if (en && bus.o_dout_valid && bus.i_dout_ready) begin
        pop_i = 1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_empty: got valid sample %h expected no sample", bus.ov_dout);
        end else begin
          exp_d = sb.pop_front();
          n_pop++;
          $display("pop %0d: got %h expected %h", n_pop, bus.ov_dout, exp_d);
          check("dout", 32'(bus.ov_dout), 32'(exp_d));
        end
      end
      if (en && bus.i_din_valid && m_level < DEPTH) begin
        sb.push_back(bus.iv_din);
        push_i = 1;
      end
      m_level = m_level + push_i - pop_i;
    end
  end

  task automatic step(input logic e, input logic v, input logic r, input logic c,
                      input logic [DW-1:0] d);
    en               = e;
    bus.i_din_valid  = v;
    bus.i_dout_ready = r;
    clr              = c;
    bus.iv_din       = d;
    @(posedge clk);
    #1;
    en               = 1'b1;
    bus.i_din_valid  = 1'b0;
    bus.i_dout_ready = 1'b0;
    clr              = 1'b0;
  endtask

  typedef struct {
    logic          en;
    logic          v;
    logic          rdy;
    logic          clr;
    logic [DW-1:0] d;
    logic [4:0]    lvl;
    logic          af;
    logic          drdy;
    logic          valid;
    logic          chk_v;
    logic          ovf;
    logic [15:0]   drops;
  } vec_t;

  function automatic vec_t mk(input logic e, v, r, c, input logic [DW-1:0] d,
                              input int l, input logic a, dr, va, cv, o,
                              input int dc);
    vec_t t;
    t.en = e; t.v = v; t.rdy = r; t.clr = c; t.d = d;
    t.lvl = 5'(l); t.af = a; t.drdy = dr; t.valid = va; t.chk_v = cv;
    t.ovf = o; t.drops = 16'(dc);
    return t;
  endfunction

  localparam int NVEC = 26;
  vec_t vec [NVEC];

  initial begin
    int sent;
    int lv;
    logic v;

    // Fill/overflow: 20 pushes with the FIR stalled.
    for (int i = 1; i <= 20; i++) begin
      lv = (i > DEPTH) ? DEPTH : i;
      vec[i-1] = mk(1, 1, 0, 0, 24'(i), lv, lv >= AFT, lv < DEPTH, i >= 2, 1,
                    i > DEPTH, (i > DEPTH) ? i - DEPTH : 0);
    end
    // Enable low: strobes ignored.
    for (int i = 20; i < 23; i++) vec[i] = mk(0, 1, 0, 0, 24'd99, 16, 1, 0, 1, 1, 1, 4);
    // Clear together with a drop: the drop wins.
    vec[23] = mk(1, 1, 0, 1, 24'd77, 16, 1, 0, 1, 1, 1, 1);
    // Full with simultaneous push and pop: pop happens, push dropped.
    vec[24] = mk(1, 1, 1, 0, 24'd78, 15, 1, 1, 0, 0, 1, 2);
    // Clear alone.
    vec[25] = mk(1, 0, 0, 1, 24'd0, 15, 1, 1, 1, 1, 0, 0);

    rst = 1'b1; en = 1'b1; clr = 1'b0;
    bus.iv_din = '0; bus.i_din_valid = 1'b0; bus.i_dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(bus.o_dout_valid), 32'd0);
    check("rst_dout", 32'(bus.ov_dout), 32'd0);
    check("rst_din_ready", 32'(bus.o_din_ready), 32'd0);
    check("rst_af", 32'(af), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drops", 32'(drops), 32'd0);

    rst = 1'b0;
    mon_on = 1'b1;
    step(1, 0, 0, 0, 0);
    check("rel_din_ready", 32'(bus.o_din_ready), 32'd1);

    // Single sample.
    step(1, 1, 0, 0, 24'h000123);
    check("single_level1", 32'(level), 32'd1);
    step(1, 0, 0, 0, 0);
    check("single_valid", 32'(bus.o_dout_valid), 32'd1);
    check("single_dout", 32'(bus.ov_dout), 32'h000123);
    step(1, 0, 1, 0, 0);
    check("single_valid_after_pop", 32'(bus.o_dout_valid), 32'd0);
    check("single_level0", 32'(level), 32'd0);

    // Ordering and pointer wrap: producer every 8 cycles, FIR every 6.
    sent = 0;
    for (int c = 0; c < 2000 && !(sent == 40 && m_level == 0); c++) begin
      v = (c % 8 == 0) && (sent < 40);
      if (v) sent++;
      step(1, v, (c % 6 == 3), 0, 24'(sent));
    end
    check("order_all_sent", 32'(sent), 32'd40);
    check("order_drained", 32'(level), 32'd0);
    check("order_no_drops", 32'(drops), 32'd0);
    check("order_no_ovf", 32'(ovf), 32'd0);

    // Vector table: fill, overflow, enable, clear, full push+pop.
    for (int k = 0; k < NVEC; k++) begin
      step(vec[k].en, vec[k].v, vec[k].rdy, vec[k].clr, vec[k].d);
      check($sformatf("vec%0d_level", k), 32'(level), 32'(vec[k].lvl));
      check($sformatf("vec%0d_af", k), 32'(af), 32'(vec[k].af));
      check($sformatf("vec%0d_din_ready", k), 32'(bus.o_din_ready), 32'(vec[k].drdy));
      check($sformatf("vec%0d_ovf", k), 32'(ovf), 32'(vec[k].ovf));
      check($sformatf("vec%0d_drops", k), 32'(drops), 32'(vec[k].drops));
      if (vec[k].chk_v)
        check($sformatf("vec%0d_valid", k), 32'(bus.o_dout_valid), 32'(vec[k].valid));
    end

    // Drain remaining samples 2..16.
    for (int c = 0; c < 100 && m_level != 0; c++) step(1, 0, 1, 0, 0);
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(bus.o_dout_valid), 32'd0);
    check("drain_pops", 32'(n_pop), 32'd57);

    // Mid-operation reset with 9 samples held.
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 24'(100 + i));
    step(1, 0, 0, 0, 0);
    check("pre_rst_level", 32'(level), 32'd9);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.o_dout_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_dout", 32'(bus.ov_dout), 32'd0);
    check("mid_rst_din_ready", 32'(bus.o_din_ready), 32'd0);
    step(1, 0, 0, 0, 0);
    check("post_rst_din_ready", 32'(bus.o_din_ready), 32'd1);
    step(1, 1, 0, 0, 24'hABCDEF);
    step(1, 0, 0, 0, 0);
    check("post_rst_valid", 32'(bus.o_dout_valid), 32'd1);
    check("post_rst_dout", 32'(bus.ov_dout), 32'hABCDEF);
    for (int c = 0; c < 20 && m_level != 0; c++) step(1, 0, 1, 0, 0);
    check("final_level", 32'(level), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
